// File: rtl/t_latch_if.sv
// t_latch_if: toggle-register bus; master drives t, slave returns q and q_bar
//   t     : per-bit toggle enable (master -> slave)
//   q     : registered state      (slave -> master)
//   q_bar : bitwise complement of q (slave -> master)
interface t_latch_if #(parameter int WIDTH = 1);
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  modport master(output t, input q, input q_bar);
  modport slave(input t, output q, output q_bar);
endinterface

// File: rtl/t_latch.sv
// t_latch: WIDTH independent edge-triggered toggle flops with synchronous active-low reset
//   clk   : rising-edge clock, the only event that changes state
//   rst_n : synchronous active-low reset, loads RESET_VAL, wins over toggle
//   bus   : slave side of t_latch_if (t in, q and q_bar out)
module t_latch #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic      clk,
  input logic      rst_n,
  t_latch_if.slave bus
);
  logic [WIDTH-1:0] r_q;
  // Per-bit if: an unknown t takes the else path, so only a definite 1 toggles.
  always_ff @(posedge clk) begin
    if (!rst_n) r_q <= RESET_VAL;
    else
      for (int i = 0; i < WIDTH; i++)
        if (bus.t[i]) r_q[i] <= ~r_q[i];
  end
  assign bus.q     = r_q;
  assign bus.q_bar = ~r_q;
endmodule

// File: tb/tb_t_latch.sv
// tb_t_latch: directed self-checking bench for t_latch (WIDTH=1 and WIDTH=4 instances)
module tb_t_latch;
  logic clk = 1'b0;
  logic rst_n;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;

  t_latch_if #(.WIDTH(1)) b1();
  t_latch_if #(.WIDTH(4)) b4();
  t_latch #(.WIDTH(1), .RESET_VAL(1'b0))    u1(.clk(clk), .rst_n(rst_n), .bus(b1));
  t_latch #(.WIDTH(4), .RESET_VAL(4'b1010)) u4(.clk(clk), .rst_n(rst_n), .bus(b4));

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Model: each bit is its reset value flipped once per edge that saw t==1 since the last reset.
  bit seen = 0;
  int n1 = 0;
  int n4[4] = '{0, 0, 0, 0};
  logic [3:0] m4;
  logic       m1;
  always @(posedge clk) begin
    if (rst_n === 1'b0) begin
      seen = 1;
      n1 = 0;
      foreach (n4[i]) n4[i] = 0;
    end else begin
      if (b1.t[0] === 1'b1) n1++;
      foreach (n4[i]) if (b4.t[i] === 1'b1) n4[i]++;
    end
  end
  always_comb begin
    m1 = 1'b0 ^ n1[0];
    for (int i = 0; i < 4; i++) m4[i] = (4'b1010 >> i) & 1 ^ n4[i][0];
  end

  always @(negedge clk) begin
    if (seen) begin
      chk("model_q1", {3'b0, b1.q}, {3'b0, m1});
      chk("model_q4", b4.q, m4);
      chk("qbar1", {3'b0, b1.q_bar}, {3'b0, ~b1.q});
      chk("qbar4", b4.q_bar, ~b4.q);
    end
  end

  // Directed table: inputs applied at 10k, edge at 10k+5, literal check at 10k+8.
  logic       r_tab[14]  = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1};
  logic       t1_tab[14] = '{1'bx, 1'bx, 0, 0, 1, 0, 1, 0, 1, 1, 0, 1, 1, 1};
  logic [3:0] t4_tab[14] = '{4'b1111, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1111, 4'b0000,
                             4'b0110, 4'b1001, 4'b1111, 4'b0000, 4'b0101, 4'b1111, 4'b0011};
  logic       q1_tab[14] = '{0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 1, 0, 1};
  logic [3:0] q4_tab[14] = '{4'b1010, 4'b1011, 4'b1001, 4'b1101, 4'b0101, 4'b1010, 4'b1010,
                             4'b1100, 4'b0101, 4'b1010, 4'b1010, 4'b1111, 4'b1010, 4'b1001};

  initial begin
    for (int k = 0; k < 14; k++) begin
      rst_n = r_tab[k];
      b1.t  = t1_tab[k];
      b4.t  = t4_tab[k];
      #8;
      chk("dir_q1", {3'b0, b1.q}, {3'b0, q1_tab[k]});
      chk("dir_qbar1", {3'b0, b1.q_bar}, {3'b0, ~q1_tab[k]});
      chk("dir_q4", b4.q, q4_tab[k]);
      #2;
    end
    // Pulse on t entirely between edges must not reach q.
    rst_n = 1; b1.t = 0; b4.t = 4'b0000;
    #1 b1.t = 1; b4.t = 4'b1111;
    #2 b1.t = 0; b4.t = 4'b0000;
    #5;
    chk("glitch_q1", {3'b0, b1.q}, 4'b0001);
    chk("glitch_q4", b4.q, 4'b1001);
    // Reset dropped between edges: nothing changes until the next rising edge.
    #1 rst_n = 0;
    #1;
    chk("midrst_hold_q1", {3'b0, b1.q}, 4'b0001);
    chk("midrst_hold_q4", b4.q, 4'b1001);
    #8;
    chk("midrst_q1", {3'b0, b1.q}, 4'b0000);
    chk("midrst_q4", b4.q, 4'b1010);
    // Held toggle: divide-by-2 on every enabled bit.
    #2 rst_n = 1; b1.t = 1; b4.t = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      #8;
      chk("div2_q1", {3'b0, b1.q}, k[0] ? 4'b0000 : 4'b0001);
      chk("div2_q4", b4.q, k[0] ? 4'b1010 : 4'b1111);
      #2;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/t_latch.md
T_LATCH -- requirements
Module: t_latch

Interface
REQ-001 Parameter WIDTH, default 1: number of independent toggle bits carried by t, q and q_bar.
REQ-002 Parameter RESET_VAL, default all-zeros (WIDTH bits): value loaded into q by reset.
REQ-003 clk  input  1  single clock; all state changes occur on its rising edge only.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 t  input  WIDTH  toggle enable, one bit per state bit.
REQ-006 q  output  WIDTH  registered state.
REQ-007 q_bar  output  WIDTH  bitwise complement of q.

Function
REQ-008 The block SHALL be edge-triggered on the rising edge of clk, despite the "latch" name; there SHALL be no level-transparent path from t to q.
REQ-009 At a rising edge with rst_n==1 and t[i]==1, q[i] SHALL invert (latency one edge).
REQ-010 At a rising edge with rst_n==1 and t[i]==0, q[i] SHALL hold its value.
REQ-011 If t[i] is X/Z at a rising edge, q[i] SHALL hold its value, since only t[i]==1'b1 toggles.
REQ-012 Bits SHALL be independent; toggling bit i SHALL NOT affect any other bit.
REQ-013 q_bar SHALL equal ~q at all times, combinationally, with no extra register and no skew cycle.
REQ-014 Changes on t or rst_n between clock edges SHALL have no effect until the next rising edge.
REQ-015 With t held at 1, q SHALL alternate every rising edge, giving a divide-by-2 of clk per bit.

Reset
REQ-016 At a rising edge with rst_n==0, q SHALL load RESET_VAL and q_bar SHALL load ~RESET_VAL, regardless of t.
REQ-017 Reset SHALL take priority over toggle when both are active at the same edge.
REQ-018 Asserting rst_n low mid-operation SHALL NOT change q until the next rising edge; it is purely synchronous, with no asynchronous path.
REQ-019 q is undefined before the first rising edge with rst_n==0; the environment SHALL apply reset for at least one edge before use.
REQ-020 On the first edge after rst_n returns high, normal toggle/hold behaviour SHALL apply.

Verification (WIDTH=1, RESET_VAL=0, clk period 10, rising edges at 5, 15, 25, ...)
REQ-021 rst_n=0 at the edge at 5 -> q=0, q_bar=1; rst_n rises at 10 with t undriven (X) -> q stays 0 after the edge at 15.
REQ-022 t=0 from 20 to 40 -> q holds 0 across the edges at 25 and 35; t=1 at 40 -> q=1 after 45; t=0 at 50 -> q holds 1 at 55.
REQ-023 t=1 at 60 -> q=0 after 65; t=1 held from 80 to 100 -> q=1 after 85, then q=0 after 95; t=0 at 100 -> q holds 0 at 105.
REQ-024 t=1 at 110 -> q=1 after 115; rst_n=0 at 120 with t=1 -> q=0 after 125, so reset wins over toggle.
REQ-025 rst_n driven low between edges -> q unchanged until the next rising edge, then 0.
REQ-026 At every sampled instant, assert q_bar == ~q with no X once reset has been applied.
